// File: rtl/mult_host.sv
// ============================================================================
// Module   : mult_host
// Brief    : Initiator-side controller for a serial Booth multiplier. It takes
//            a signed WxW request and returns the 2W-bit product, or an error
//            when the multiplier times out. Optional build macro
//            MULT_HOST_CHECK_EN adds a local product cross-check (chk_mismatch).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_host #(
    parameter int W       = 5,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [W-1:0]   req_a,
    input  logic [W-1:0]   req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*W-1:0] rsp_product,
    output logic           rsp_err,
    output logic           mul_rst,
    output logic           mul_start,
    output logic [W-1:0]   mul_data_in,
    input  logic [W-1:0]   mul_data_out,
    input  logic           mul_done
`ifdef MULT_HOST_CHECK_EN
    ,
    output logic           chk_mismatch
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        START  = 3'd2,
        SEND_A = 3'd3,
        SEND_B = 3'd4,
        WAIT   = 3'd5,
        CAP_LO = 3'd6,
        RESP   = 3'd7
    } state_t;

    localparam logic [TW-1:0] c_cnt_last = TW'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   prod_q, prod_d;
    logic             err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    state_d = CLR;
                end
            end
            CLR:    state_d = START;
            START:  state_d = SEND_A;
            SEND_A: state_d = SEND_B;
            SEND_B: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // done wins over an expiring timeout in the same cycle
                if (mul_done) begin
                    prod_d[2*W-1:W] = mul_data_out;
                    state_d         = CAP_LO;
                end else if (cnt_q == c_cnt_last) begin
                    err_d   = 1'b1;
                    prod_d  = '0;
                    state_d = RESP;
                end
            end
            CAP_LO: begin
                prod_d[W-1:0] = mul_data_out;
                state_d       = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decoded straight from state so reset drops the strobes without a clock
    always_comb begin
        req_ready   = (state_q == IDLE);
        mul_rst     = (state_q == CLR);
        mul_start   = (state_q == START);
        rsp_valid   = (state_q == RESP);
        mul_data_in = '0;
        if (state_q == SEND_A) mul_data_in = a_q;
        if (state_q == SEND_B) mul_data_in = b_q;
    end

    assign rsp_product = prod_q;
    assign rsp_err     = err_q;

`ifdef MULT_HOST_CHECK_EN
    logic signed [2*W-1:0] local_prod;
    assign local_prod   = $signed(a_q) * $signed(b_q);
    assign chk_mismatch = (state_q == RESP) && !err_q && (local_prod != $signed(prod_q));
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_host.sv
// ============================================================================
// Module   : tb_mult_host
// Brief    : Scoreboard bench for mult_host with a behavioural serial
//            multiplier model on the mul_* port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_host;

    localparam int W   = 5;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [W-1:0]   req_a = '0;
    logic [W-1:0]   req_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [2*W-1:0] rsp_product;
    logic           rsp_err;
    logic           mul_rst;
    logic           mul_start;
    logic [W-1:0]   mul_data_in;
    logic [W-1:0]   mul_data_out = '0;
    logic           mul_done = 1'b0;
`ifdef MULT_HOST_CHECK_EN
    logic           chk_mismatch;
`endif

    int total = 0;
    int bad   = 0;
    int n_start = 0;
    logic m_never = 1'b0;

    logic [2*W:0] exp_q[$];

    mult_host #(.W(W), .TIMEOUT(64), .TW(7)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_product  (rsp_product),
        .rsp_err      (rsp_err),
        .mul_rst      (mul_rst),
        .mul_start    (mul_start),
        .mul_data_in  (mul_data_in),
        .mul_data_out (mul_data_out),
        .mul_done     (mul_done)
`ifdef MULT_HOST_CHECK_EN
        ,
        .chk_mismatch (chk_mismatch)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Multiplier model: sample A then B after start, done with hi after LAT, lo next cycle
    int           m_phase = 0;
    int           m_cnt   = 0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [2*W-1:0] m_prod;
    assign m_prod = $signed({{W{m_a[W-1]}}, m_a}) * $signed({{W{m_b[W-1]}}, m_b});

    always @(posedge clk) begin
        mul_done <= 1'b0;
        if (!rst) begin
            m_phase      <= 0;
            mul_data_out <= '0;
        end else if (mul_start) begin
            m_phase <= 1;
        end else begin
            case (m_phase)
                1: begin m_a <= mul_data_in; m_phase <= 2; end
                2: begin m_b <= mul_data_in; m_phase <= 3; m_cnt <= 0; end
                3: if (!m_never) begin
                    if (m_cnt == LAT - 1) begin
                        mul_done     <= 1'b1;
                        mul_data_out <= m_prod[2*W-1:W];
                        m_phase      <= 4;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
                4: begin mul_data_out <= m_prod[W-1:0]; m_phase <= 0; end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(posedge clk) if (rst === 1'b1 && mul_start === 1'b1) n_start++;

    // Monitor: pop one expectation per response handshake
    always @(negedge clk) begin
        logic [2*W:0] e;
        if (rst === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_product), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("rsp_product", 32'(rsp_product), 32'(e[2*W-1:0]));
                check("rsp_err", 32'(rsp_err), 32'(e[2*W]));
`ifdef MULT_HOST_CHECK_EN
                check("chk_mismatch", 32'(chk_mismatch), 32'd0);
`endif
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) check("req_ready_wait", 32'(req_ready), 32'd1);
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        @(negedge clk);
        while (!(rsp_valid === 1'b1 && rsp_ready === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("rsp_wait", 32'(rsp_valid), 32'd1);
        @(posedge clk);
    endtask

    task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] p);
        exp_q.push_back({1'b0, p});
        issue(a, b);
        wait_rsp();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_mul_rst"}, 32'(mul_rst), 32'd0);
        check({tag, "_mul_start"}, 32'(mul_start), 32'd0);
        check({tag, "_mul_data_in"}, 32'(mul_data_in), 32'd0);
        check({tag, "_rsp_product"}, 32'(rsp_product), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        int n;
        int starts0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b1;

        // -15 * 9 = -135
        txn(5'b10001, 5'b01001, 10'b1101111001);

        // 9 * -15, with the operand bus sequence observed
        exp_q.push_back({1'b0, 10'b1101111001});
        issue(5'b01001, 5'b10001);
        @(negedge clk); check("clr_mul_rst", 32'(mul_rst), 32'd1);
        @(negedge clk); check("start_pulse", 32'(mul_start), 32'd1);
        @(negedge clk); check("data_in_a", 32'(mul_data_in), 32'b01001);
        @(negedge clk); check("data_in_b", 32'(mul_data_in), 32'b10001);
        wait_rsp();

        // Timeout: model never answers
        m_never = 1'b1;
        exp_q.push_back({1'b1, 10'd0});
        issue(5'd3, 5'd3);
        repeat (4) @(negedge clk);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) break;
            n++;
        end
        check("timeout_latency", 32'(n), 32'd64);
        @(posedge clk);
        m_never = 1'b0;
        repeat (4) @(posedge clk);

        // Back-pressure: 3 * -2 = -6 held for 10 cycles
        rsp_ready = 1'b0;
        exp_q.push_back({1'b0, 10'b1111111010});
        issue(5'd3, 5'b11110);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_product", 32'(rsp_product), 32'b1111111010);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_hs_req_ready", 32'(req_ready), 32'd1);
        check("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);

        // Reset during WAIT aborts without a response
        issue(5'd5, 5'd5);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("mid_rst_mul_done_wait", 32'(rsp_valid), 32'd0);
        check_idle_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        txn(5'd7, 5'b11101, 10'b1111101011);

        // Back-to-back corner operands
        starts0 = n_start;
        txn(5'b10000, 5'b10000, 10'b0100000000);
        txn(5'b01111, 5'b01111, 10'b0011100001);
        txn(5'b10000, 5'b01111, 10'b1100010000);
        txn(5'b00000, 5'b11001, 10'b0000000000);
        txn(5'b11111, 5'b00001, 10'b1111111111);
        check("start_count", 32'(n_start - starts0), 32'd5);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
